// File: rtl/alu_pkg.sv
// Shared ALU op encoding and helpers.
// Imported by the ALU control decoder and the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SRA  = 4'b0110,
    OP_RSV7 = 4'b0111,
    OP_BEQ  = 4'b1000,
    OP_BNE  = 4'b1001,
    OP_BLT  = 4'b1010,
    OP_BGE  = 4'b1011,
    OP_SLT  = 4'b1100,
    OP_SLL  = 4'b1101,
    OP_RSVE = 4'b1110,
    OP_RSVF = 4'b1111
  } alu_op_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } alu_state_t;

  function automatic logic is_shift(
    input alu_op_t op
  );
    return (op == OP_SRL) ||
           (op == OP_SRA) ||
           (op == OP_SLL);
  endfunction

  function automatic logic is_compare(
    input alu_op_t op
  );
    return (op == OP_BEQ) ||
           (op == OP_BNE) ||
           (op == OP_BLT) ||
           (op == OP_BGE) ||
           (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: logic, add/sub and compares.
// Shift and reserved ops yield zero here; shifts are iterated upstream.
module alu_comb
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  alu_op_t           i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result,
  output logic              o_cond
);

  logic w_eq;
  logic w_lt;
  logic w_cond;

  assign w_eq = (i_a == i_b);
  assign w_lt = ($signed(i_a) < $signed(i_b));

  always_comb begin
    w_cond = 1'b0;
    case (i_op)
      OP_BEQ:  w_cond = w_eq;
      OP_BNE:  w_cond = !w_eq;
      OP_BLT:  w_cond = w_lt;
      OP_BGE:  w_cond = !w_lt;
      OP_SLT:  w_cond = w_lt;
      default: w_cond = 1'b0;
    endcase
  end

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      default: o_result = '0;
    endcase
    if (is_compare(i_op)) begin
      o_result = {{(DATA_W-1){1'b0}}, w_cond};
    end
  end

  assign o_cond = w_cond;

endmodule

// File: rtl/seq_alu.sv
// Register-based ALU with start/busy/done handshake.
// Single-cycle ops finish in one clock; shifts step one bit per clock.
module seq_alu
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        operation,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              branch_taken,
  output logic              zero
);

  alu_state_t          r_state;
  alu_op_t             r_op;
  logic [DATA_W-1:0]   r_acc;
  logic [SHAMT_W-1:0]  r_cnt;

  alu_op_t             w_op;
  logic                w_shift;
  logic [SHAMT_W-1:0]  w_shamt;
  logic [DATA_W-1:0]   w_res;
  logic                w_cond;
  logic [DATA_W-1:0]   w_imm;
  logic [DATA_W-1:0]   w_step;

  assign w_op    = alu_op_t'(operation);
  assign w_shift = is_shift(w_op);
  assign w_shamt = src_b[SHAMT_W-1:0];

  alu_comb #(
    .DATA_W (DATA_W)
  ) u_comb (
    .i_op     (w_op),
    .i_a      (src_a),
    .i_b      (src_b),
    .o_result (w_res),
    .o_cond   (w_cond)
  );

  // A zero-distance shift completes like any single-cycle op.
  assign w_imm = w_shift ? src_a : w_res;

  always_comb begin
    w_step = {r_acc[DATA_W-2:0], 1'b0};
    case (r_op)
      OP_SRL:  w_step = {1'b0, r_acc[DATA_W-1:1]};
      OP_SRA:  w_step = {r_acc[DATA_W-1], r_acc[DATA_W-1:1]};
      default: w_step = {r_acc[DATA_W-2:0], 1'b0};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_op         <= OP_AND;
      r_acc        <= '0;
      r_cnt        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      branch_taken <= 1'b0;
      zero         <= 1'b1;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_shift && (w_shamt != '0)) begin
              r_acc   <= src_a;
              r_cnt   <= w_shamt;
              r_op    <= w_op;
              busy    <= 1'b1;
              r_state <= S_SHIFT;
            end else begin
              result       <= w_imm;
              branch_taken <= w_cond;
              zero         <= (w_imm == '0);
              done         <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          // Final step writes straight to the output registers.
          if (r_cnt == SHAMT_W'(1)) begin
            result       <= w_step;
            branch_taken <= 1'b0;
            zero         <= (w_step == '0);
            done         <= 1'b1;
            busy         <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_acc <= w_step;
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed vectors, queued expectations,
// independent done monitor checking value, flags and latency.
module tb_seq_alu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  operation;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        branch_taken;
  logic        zero;

  seq_alu #(
    .DATA_W  (32),
    .SHAMT_W (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .operation    (operation),
    .src_a        (src_a),
    .src_b        (src_b),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .branch_taken (branch_taken),
    .zero         (zero)
  );

  typedef struct {
    logic [31:0] res;
    logic        bt;
    logic        z;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t e_m;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done: result %h at cycle %0d", result, cyc);
      end else begin
        e_m = q.pop_front();
        chk("result", result, e_m.res);
        chk("branch_taken", {31'b0, branch_taken}, {31'b0, e_m.bt});
        chk("zero", {31'b0, zero}, {31'b0, e_m.z});
        chk("latency_cycle", cyc, e_m.due);
      end
    end
  end

  // Called at 1ns after a posedge; start is sampled on the next edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res,
                       input logic bt, input int lat, input bit acc);
    exp_t e;
    start     = 1'b1;
    operation = op;
    src_a     = a;
    src_b     = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    src_a = 32'hDEAD_BEEF;
    src_b = 32'hDEAD_BEEF;
    if (acc) begin
      e.res = res;
      e.bt  = bt;
      e.z   = (res == 32'h0);
      e.due = cyc + lat;
      q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (q.size() != 0 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: %0d pending at cycle %0d", q.size(), cyc);
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic busy_for(input string nm, input logic exp, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(nm, {31'b0, busy}, {31'b0, exp});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc       = 0;
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    start     = 1'b0;
    operation = 4'b0000;
    src_a     = '0;
    src_b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_branch", {31'b0, branch_taken}, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single-cycle ops; busy must never rise.
    issue(4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 0, 1);
    @(negedge clk);
    chk("add_busy", {31'b0, busy}, 32'd0);
    wait_idle();
    issue(4'b0011, 32'd5, 32'd5, 32'h0, 1'b0, 0, 1);
    wait_idle();
    issue(4'b0100, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 1'b0, 0, 1);
    wait_idle();
    issue(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 0, 1);
    wait_idle();
    issue(4'b0001, 32'hF000_0001, 32'h0000_1000, 32'hF000_1001, 1'b0, 0, 1);
    wait_idle();

    // Signed compares
    issue(4'b1010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 0, 1);
    wait_idle();
    issue(4'b1011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0, 1);
    wait_idle();
    issue(4'b1000, 32'd7, 32'd7, 32'd1, 1'b1, 0, 1);
    wait_idle();
    issue(4'b1001, 32'd7, 32'd7, 32'd0, 1'b0, 0, 1);
    wait_idle();
    issue(4'b1100, 32'd3, 32'hFFFF_FFFE, 32'd0, 1'b0, 0, 1);
    wait_idle();
    issue(4'b1100, 32'hFFFF_FFFE, 32'd3, 32'd1, 1'b1, 0, 1);
    wait_idle();

    // Iterative shifts; busy high for exactly shamt cycles.
    issue(4'b0110, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 4, 1);
    busy_for("sra_busy", 1'b1, 4);
    wait_idle();
    issue(4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 4, 1);
    wait_idle();
    issue(4'b1101, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 31, 1);
    wait_idle();
    issue(4'b0101, 32'h0000_ABCD, 32'hFFFF_FFE0, 32'h0000_ABCD, 1'b0, 0, 1);
    @(negedge clk);
    chk("shamt0_busy", {31'b0, busy}, 32'd0);
    wait_idle();

    // Start ignored while busy, then accepted in the done cycle.
    issue(4'b1101, 32'h1, 32'd10, 32'h0000_0400, 1'b0, 10, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    issue(4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 0, 0);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("b2b_done_now", {31'b0, done}, 32'd1);
    issue(4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 0, 1);
    wait_idle();

    // Reserved op
    issue(4'b1110, 32'h1234, 32'h5678, 32'h0, 1'b0, 0, 1);
    wait_idle();

    // Leave a nonzero result so the reset check is meaningful.
    issue(4'b0001, 32'h55, 32'h0, 32'h55, 1'b0, 0, 1);
    wait_idle();

    // Reset mid-shift abandons the op.
    issue(4'b0101, 32'hF000_0000, 32'd20, 32'h0, 1'b0, 20, 0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    chk("mid_rst_result", result, 32'h0);
    chk("mid_rst_zero", {31'b0, zero}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    chk("post_rst_busy", {31'b0, busy}, 32'd0);
    chk("post_rst_result", result, 32'h0);

    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_expect: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
